// File: rtl/dcache_pkg.sv
//------------------------------------------------------------------------------
// dcache_pkg : shared types and geometry helpers for the direct-mapped dcache.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WACK  = 2'd3
    } state_t;

    localparam int c_addr_width = 32;
    localparam int c_index_bits = 4;
    localparam int c_num_lines  = 2 ** c_index_bits;
    localparam int c_tag_width  = c_addr_width - c_index_bits - 2;

    // Geometry for non-default parameterisations of the cache.
    function automatic int num_lines(input int index_bits);
        return 2 ** index_bits;
    endfunction

    function automatic int tag_width(input int addr_width, input int index_bits);
        return addr_width - index_bits - 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
//------------------------------------------------------------------------------
// dcache_line_store : valid/tag/data arrays, async lookup, single sync write.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_WIDTH  = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_WIDTH-1:0]  o_rd_tag,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_WIDTH-1:0]  i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    localparam int c_lines = num_lines(INDEX_BITS);

    logic [c_lines-1:0]    r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [c_lines];
    logic [DATA_WIDTH-1:0] r_data [c_lines];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/dcache.sv
//------------------------------------------------------------------------------
// dcache : direct-mapped, write-through, write-allocate single-word-line cache.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_rd,
    input  logic                  cache_wr,
    input  logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [DATA_WIDTH-1:0] cache_data,
    output logic                  cache_waitrequest,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_waitrequest
);

    localparam int c_tag_w = tag_width(ADDR_WIDTH, INDEX_BITS);

    state_t r_state;

    logic [INDEX_BITS-1:0] w_index;
    logic [c_tag_w-1:0]    w_tag;
    logic                  w_line_valid;
    logic [c_tag_w-1:0]    w_line_tag;
    logic [DATA_WIDTH-1:0] w_line_data;
    logic                  w_hit;
    logic                  w_line_we;
    logic [DATA_WIDTH-1:0] w_line_wdata;
    logic                  w_unused;

    assign w_index  = cache_addr[INDEX_BITS+1:2];
    assign w_tag    = cache_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_hit    = w_line_valid && (w_line_tag == w_tag);
    assign w_unused = ^cache_addr[1:0];

    dcache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_WIDTH  (c_tag_w),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk        (clock),
        .rst        (reset),
        .i_rd_index (w_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_line_we),
        .i_wr_index (w_index),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_line_wdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cache_wr) begin
                        r_state <= ST_WRITE;
                    end else if (cache_rd && !w_hit) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL:  if (!mem_waitrequest) r_state <= ST_IDLE;
                ST_WRITE: if (!mem_waitrequest) r_state <= ST_WACK;
                ST_WACK:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // A reset edge that lands on the completing memory cycle must not allocate.
    always_comb begin
        w_line_we    = !reset && !mem_waitrequest
                       && ((r_state == ST_FILL) || (r_state == ST_WRITE));
        w_line_wdata = (r_state == ST_WRITE) ? cache_wr_data : mem_rd_data;
    end

    assign mem_rd      = (r_state == ST_FILL);
    assign mem_wr      = (r_state == ST_WRITE);
    assign mem_addr    = {cache_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wr_data = cache_wr_data;

    always_comb begin
        cache_waitrequest = 1'b1;
        cache_data        = '0;
        case (r_state)
            ST_IDLE: begin
                cache_waitrequest = cache_wr || (cache_rd && !w_hit);
                if (cache_rd && !cache_wr && w_hit) begin
                    cache_data = w_line_data;
                end
            end
            ST_WACK: cache_waitrequest = 1'b0;
            default: cache_waitrequest = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache.sv
//------------------------------------------------------------------------------
// tb_dcache : scoreboard bench for dcache against a behavioural cache model.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dcache;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] cache_addr;
    logic          cache_rd;
    logic          cache_wr;
    logic [DW-1:0] cache_wr_data;
    logic [DW-1:0] cache_data;
    logic          cache_waitrequest;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          mem_waitrequest;

    dcache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .cache_addr        (cache_addr),
        .cache_rd          (cache_rd),
        .cache_wr          (cache_wr),
        .cache_wr_data     (cache_wr_data),
        .cache_data        (cache_data),
        .cache_waitrequest (cache_waitrequest),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_wr            (mem_wr),
        .mem_wr_data       (mem_wr_data),
        .mem_rd_data       (mem_rd_data),
        .mem_waitrequest   (mem_waitrequest)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        bit            is_wr;
        logic [DW-1:0] rdata;
        logic [DW-1:0] wdata;
        int            mem_cycles;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Backing memory seen by the DUT, and the reference model's own view.
    logic [DW-1:0] mem     [logic [29:0]];
    logic [DW-1:0] ref_mem [logic [29:0]];
    bit            ref_valid [16];
    logic [25:0]   ref_tag   [16];

    function automatic logic [DW-1:0] init_word(input logic [29:0] w);
        return {w, 2'b01} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One pipeline transaction; the model decides hit/miss from the address alone.
    task automatic txn(input logic [AW-1:0] a, input bit rd, input bit wr,
                       input logic [DW-1:0] d, input int waits);
        exp_t e;
        int   cnt = waits;
        int   n   = 0;
        bit   done = 0;
        int   idx = int'(a[5:2]);
        logic [29:0] w = a[31:2];
        e.addr  = {a[31:2], 2'b00};
        e.is_wr = wr;
        e.wdata = d;
        e.rdata = '0;
        if (wr) begin
            e.mem_cycles = waits + 1;
            ref_mem[w]   = d;
        end else begin
            e.mem_cycles = (ref_valid[idx] && ref_tag[idx] == a[31:6]) ? 0 : waits + 1;
            e.rdata      = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
        end
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a[31:6];
        q.push_back(e);
        cache_addr = a; cache_rd = rd; cache_wr = wr; cache_wr_data = d;
        while (!done && n < 64) begin
            mem_waitrequest = 1'b0;
            if (mem_rd || mem_wr) begin
                mem_waitrequest = (cnt > 0);
                if (cnt > 0) cnt--;
            end
            mem_rd_data = mem_rd ? (mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]]
                                                                : init_word(mem_addr[31:2]))
                                 : $urandom;
            @(negedge clock);
            if (mem_wr && !mem_waitrequest) mem[mem_addr[31:2]] = mem_wr_data;
            if ((cache_rd || cache_wr) && !cache_waitrequest) done = 1;
            @(posedge clock); #1;
            n++;
        end
        if (!done) begin
            chk("txn_timeout", 32'(n), 32'd0);
            q.delete();
        end
        cache_rd = 1'b0; cache_wr = 1'b0; mem_waitrequest = 1'b0;
    endtask

    // Monitor: strobe accounting and scoreboard pop on every accepted transfer.
    initial begin
        int   rd_cyc = 0;
        int   wr_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                rd_cyc = 0; wr_cyc = 0;
            end else begin
                if (mem_rd && mem_wr) chk("strobe_overlap", 32'd1, 32'd0);
                if (mem_rd) begin
                    rd_cyc++;
                    if (q.size() > 0) chk("fill_addr", mem_addr, q[0].addr);
                end
                if (mem_wr) begin
                    wr_cyc++;
                    if (q.size() > 0) begin
                        chk("write_addr", mem_addr, q[0].addr);
                        chk("write_data", mem_wr_data, q[0].wdata);
                    end
                end
                if (!cache_rd && !cache_wr) begin
                    chk("idle_waitreq", 32'(cache_waitrequest), 32'd0);
                    chk("idle_data", cache_data, 32'd0);
                end else if (!cache_waitrequest) begin
                    if (q.size() == 0) begin
                        chk("unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        if (e.is_wr) begin
                            chk("wr_mem_wr_cycles", 32'(wr_cyc), 32'(e.mem_cycles));
                            chk("wr_mem_rd_cycles", 32'(rd_cyc), 32'd0);
                        end else begin
                            chk("rd_mem_rd_cycles", 32'(rd_cyc), 32'(e.mem_cycles));
                            chk("rd_mem_wr_cycles", 32'(wr_cyc), 32'd0);
                            chk("rd_data", cache_data, e.rdata);
                        end
                    end
                    rd_cyc = 0; wr_cyc = 0;
                end
            end
        end
    end

    a_no_dual_strobe: assert property (@(posedge clock) !(mem_rd && mem_wr))
        else begin
            miscompares++;
            $display("FAIL assert_dual_strobe: mem_rd=1 mem_wr=1 required not both");
        end

    a_wack_single: assert property (@(posedge clock) disable iff (reset)
        (cache_wr && !cache_waitrequest) |=> !(cache_wr && !cache_waitrequest))
        else begin
            miscompares++;
            $display("FAIL assert_wack_single: write accepted twice, required once");
        end

    initial begin
        logic [AW-1:0] a;
        bit            r, wbit;
        reset = 1'b1; cache_addr = '0; cache_rd = 0; cache_wr = 0; cache_wr_data = '0;
        mem_rd_data = '0; mem_waitrequest = 1'b0;
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        mem[30'h40]     = 32'hDEADBEEF;
        ref_mem[30'h40] = 32'hDEADBEEF;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_waitreq", 32'(cache_waitrequest), 32'd0);
        chk("reset_data", cache_data, 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_mem_wr", 32'(mem_wr), 32'd0);
        @(posedge clock); #1;

        txn(32'h100, 1, 0, '0, 2);            // fill after two wait cycles
        txn(32'h100, 1, 0, '0, 0);            // zero-wait hit
        txn(32'h104, 0, 1, 32'h55AA55AA, 0);
        txn(32'h104, 1, 0, '0, 0);
        txn(32'h100, 1, 0, '0, 1);
        txn(32'h140, 1, 0, '0, 1);            // same index, different tag
        txn(32'h100, 1, 0, '0, 0);
        txn(32'h108, 1, 1, 32'h12345678, 1);  // write wins over read
        txn(32'h108, 1, 0, '0, 0);

        // Reset in the middle of a stalled fill.
        cache_addr = 32'h200; cache_rd = 1'b1; mem_waitrequest = 1'b1;
        @(negedge clock);
        chk("miss_waitreq", 32'(cache_waitrequest), 32'd1);
        @(posedge clock); #1;
        chk("fill_mem_rd", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        chk("abort_mem_wr", 32'(mem_wr), 32'd0);
        cache_rd = 1'b0; reset = 1'b0; mem_waitrequest = 1'b0;
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        @(posedge clock); #1;
        txn(32'h200, 1, 0, '0, 0);

        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 3)) << 6;
            a[31] = 1'($urandom_range(0, 1));
            a[5:2] = 4'($urandom);
            a[1:0] = 2'($urandom);
            wbit = ($urandom_range(0, 2) == 0);
            r    = !wbit || ($urandom_range(0, 3) == 0);
            txn(a, r, wbit, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end

        repeat (4) @(posedge clock);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
